// File: rtl/pe_scatter_pkg.sv
// Shared types and arithmetic helpers for the PE scatter-accumulate stage.
// PE_SCATTER_SAT_EN selects saturating accumulation; the default build wraps.
package pe_scatter_pkg;

    typedef enum logic [1:0] {S_ACC, S_FLUSH, S_DRAIN, S_DONE} state_t;

    function automatic int prod_width(input int w_w, input int ia_w);
        return w_w + ia_w;
    endfunction

    function automatic logic [64:0] acc_max(input int unsigned w);
        return (65'd1 << w) - 65'd1;
    endfunction

    // Operands are zero-extended to 64 bits; w is the real entry width (<= 63).
    function automatic logic acc_ovf(input logic [63:0] a, input logic [63:0] b,
                                     input int unsigned w);
        return ({1'b0, a} + {1'b0, b}) > acc_max(w);
    endfunction

    function automatic logic [63:0] acc_sum(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] s;
        logic [64:0] m;
        s = {1'b0, a} + {1'b0, b};
        m = acc_max(w);
`ifdef PE_SCATTER_SAT_EN
        return (s > m) ? 64'(m) : 64'(s);
`else
        return 64'(s & m);
`endif
    endfunction

endpackage

// File: rtl/pe_scatter_accum_if.sv
// Beat input and drain output handshakes of the PE scatter-accumulate stage.
interface pe_scatter_accum_if #(
    parameter int LANES  = 3,
    parameter int W_W    = 16,
    parameter int IA_W   = 16,
    parameter int ADDR_W = 7,
    parameter int ACC_W  = 36
);
    logic                          valid;
    logic                          ready;
    logic [LANES-1:0]              lane_en;
    logic [LANES-1:0][W_W-1:0]     w;
    logic [LANES-1:0][IA_W-1:0]    ia;
    logic [LANES-1:0][ADDR_W-1:0]  addr;
    logic                          out_valid;
    logic                          out_ready;
    logic [ADDR_W-1:0]             out_addr;
    logic [ACC_W-1:0]              out_data;

    modport master (output valid, lane_en, w, ia, addr, out_ready,
                    input  ready, out_valid, out_addr, out_data);
    modport slave  (input  valid, lane_en, w, ia, addr, out_ready,
                    output ready, out_valid, out_addr, out_data);
endinterface

// File: rtl/pe_scatter_accum_merge.sv
// P2 lane merge: sums products of lanes sharing an address; only the lowest
// lane of each address group keeps its write-enable.
module pe_lane_merge
    import pe_scatter_pkg::*;
#(
    parameter int LANES  = 3,
    parameter int PW     = 32,
    parameter int ADDR_W = 7,
    parameter int ACC_W  = 36
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [LANES-1:0]             i_vld,
    input  logic [LANES-1:0][PW-1:0]     i_prod,
    input  logic [LANES-1:0][ADDR_W-1:0] i_addr,
    output logic [LANES-1:0]             o_we,
    output logic [LANES-1:0][ACC_W-1:0]  o_sum,
    output logic [LANES-1:0][ADDR_W-1:0] o_addr,
    output logic                         o_ovf
);
    logic [LANES-1:0]            we_c;
    logic [LANES-1:0][ACC_W-1:0] sum_c;
    logic                        ovf_c;

    always_comb begin
        we_c  = i_vld;
        sum_c = '0;
        ovf_c = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            for (int j = 0; j < LANES; j++) begin
                if (i_vld[k] && i_vld[j] && (i_addr[j] == i_addr[k])) begin
                    ovf_c    = ovf_c | acc_ovf(64'(sum_c[k]), 64'(i_prod[j]), ACC_W);
                    sum_c[k] = ACC_W'(acc_sum(64'(sum_c[k]), 64'(i_prod[j]), ACC_W));
                    if (j < k) we_c[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_we  <= '0;
            o_ovf <= 1'b0;
        end else begin
            o_we  <= we_c;
            o_ovf <= ovf_c;
        end
        o_sum  <= sum_c;
        o_addr <= i_addr;
    end
endmodule

// File: rtl/pe_scatter_accum.sv
// Scatter-accumulate of LANES weight x activation products into DEPTH entries,
// drained on request. Build with PE_SCATTER_SAT_EN for saturating entries.
//
// state   | meaning
// S_ACC   | accepting beats; i_drain starts a drain
// S_FLUSH | input closed, letting P1..P3 empty (2 cycles)
// S_DRAIN | streaming acc[idx], clearing each entry on handshake
// S_DONE  | one-cycle o_done, sticky flags cleared
module pe_scatter_accum
    import pe_scatter_pkg::*;
#(
    parameter int LANES  = 3,
    parameter int W_W    = 16,
    parameter int IA_W   = 16,
    parameter int DEPTH  = 10,
    parameter int ADDR_W = 7,
    parameter int ACC_W  = 36
) (
    input  logic               i_clk,
    input  logic               i_rst,
    pe_scatter_accum_if.slave  bus,
    input  logic               i_drain,
    output logic               o_done,
    output logic               o_addr_err,
    output logic               o_ovf
);
    localparam int PW    = prod_width(W_W, IA_W);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t                      state, state_nxt;
    logic [1:0]                  flush_cnt;
    logic [IDX_W-1:0]            idx;
    logic                        accept;
    logic [LANES-1:0]            lane_ok;
    logic [LANES-1:0]            p1_vld;
    logic [LANES-1:0][PW-1:0]    p1_prod;
    logic [LANES-1:0][ADDR_W-1:0] p1_addr;
    logic [LANES-1:0]            p2_we;
    logic [LANES-1:0][ACC_W-1:0] p2_sum;
    logic [LANES-1:0][ADDR_W-1:0] p2_addr;
    logic                        p2_ovf;
    logic [LANES-1:0]            p3_ovf;
    logic [ACC_W-1:0]            acc [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_ACC;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_ACC:   if (i_drain) state_nxt = S_FLUSH;
            S_FLUSH: if (flush_cnt == 2'd0) state_nxt = S_DRAIN;
            S_DRAIN: if (bus.out_ready && (idx == LAST_IDX)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_ACC;
            default: state_nxt = S_ACC;
        endcase
    end

    always_comb begin
        bus.ready     = (state == S_ACC);
        bus.out_valid = (state == S_DRAIN);
        o_done        = (state == S_DONE);
    end

    assign accept       = bus.valid && bus.ready;
    assign bus.out_addr = ADDR_W'(idx);
    assign bus.out_data = acc[idx];

    // Flush wait is a down-counter reloaded whenever the block is accepting.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            flush_cnt <= 2'd1;
            idx       <= '0;
        end else begin
            if (state == S_ACC)                           flush_cnt <= 2'd1;
            else if (state == S_FLUSH && flush_cnt != 2'd0) flush_cnt <= flush_cnt - 2'd1;
            if (state == S_DRAIN && bus.out_ready)
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++)
            lane_ok[k] = bus.lane_en[k] && ({1'b0, bus.addr[k]} < (ADDR_W+1)'(DEPTH));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            p1_vld     <= '0;
            o_addr_err <= 1'b0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                p1_vld[k]  <= accept && lane_ok[k];
                p1_prod[k] <= lane_ok[k] ? PW'(bus.w[k]) * PW'(bus.ia[k]) : '0;
            end
            p1_addr <= bus.addr;
            if (state == S_DONE)
                o_addr_err <= 1'b0;
            else if (accept && |(bus.lane_en & ~lane_ok))
                o_addr_err <= 1'b1;
        end
    end

    pe_lane_merge #(
        .LANES(LANES), .PW(PW), .ADDR_W(ADDR_W), .ACC_W(ACC_W)
    ) u_merge (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_vld(p1_vld), .i_prod(p1_prod), .i_addr(p1_addr),
        .o_we(p2_we), .o_sum(p2_sum), .o_addr(p2_addr), .o_ovf(p2_ovf)
    );

    always_comb begin
        p3_ovf = '0;
        for (int k = 0; k < LANES; k++)
            if (p2_we[k])
                p3_ovf[k] = acc_ovf(64'(acc[IDX_W'(p2_addr[k])]), 64'(p2_sum[k]), ACC_W);
    end

    // Merged lanes carry distinct addresses, so per-lane writes never collide.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc   <= '{default: '0};
            o_ovf <= 1'b0;
        end else begin
            if (state == S_DRAIN && bus.out_ready) acc[idx] <= '0;
            for (int k = 0; k < LANES; k++)
                if (p2_we[k])
                    acc[IDX_W'(p2_addr[k])] <= ACC_W'(acc_sum(64'(acc[IDX_W'(p2_addr[k])]),
                                                              64'(p2_sum[k]), ACC_W));
            if (state == S_DONE)
                o_ovf <= 1'b0;
            else if (p2_ovf || |p3_ovf)
                o_ovf <= 1'b1;
        end
    end
endmodule
